// File: rtl/tt_reshape_stream.sv
// rtl/tt_reshape_stream.sv - streaming corner-turn buffer, column beats in, row beats out
// Fills an X_WIDTH x Y_WIDTH bit matrix one slice per beat, then drains it one bit-plane per beat.
`timescale 1ns/1ps
module tt_reshape_stream #(
   parameter int X_WIDTH = 32,
   parameter int Y_WIDTH = 4
) (
   input  logic                                           i_clk,
   input  logic                                           i_reset,
   input  logic                                           i_in_valid,
   output logic                                           o_in_ready,
   input  logic [Y_WIDTH-1:0]                             i_in_data,
   output logic                                           o_out_valid,
   input  logic                                           i_out_ready,
   output logic [X_WIDTH-1:0]                             o_out_data,
   output logic [((Y_WIDTH > 1) ? $clog2(Y_WIDTH) : 1)-1:0] o_out_idx,
   output logic                                           o_out_last,
   input  logic                                           i_flush
);

   localparam int XC_W = (X_WIDTH > 1) ? $clog2(X_WIDTH) : 1;
   localparam int YC_W = (Y_WIDTH > 1) ? $clog2(Y_WIDTH) : 1;
   localparam logic [XC_W-1:0] X_LAST = XC_W'(X_WIDTH - 1);
   localparam logic [YC_W-1:0] Y_LAST = YC_W'(Y_WIDTH - 1);

   typedef enum logic {
      ST_FILL  = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t                          state_q, state_d;
   logic [XC_W-1:0]                 x_cnt_q, x_cnt_d;
   logic [YC_W-1:0]                 y_cnt_q, y_cnt_d;
   logic [Y_WIDTH-1:0][X_WIDTH-1:0] buf_q;
   logic                            wr_en;

   // Outputs decode from registered state only; inputs only steer the next state.
   always_comb begin
      state_d     = state_q;
      x_cnt_d     = x_cnt_q;
      y_cnt_d     = y_cnt_q;
      wr_en       = 1'b0;
      o_in_ready  = 1'b0;
      o_out_valid = 1'b0;
      o_out_data  = '0;
      o_out_idx   = '0;
      o_out_last  = 1'b0;

      case (state_q)
         ST_FILL: begin
            o_in_ready = 1'b1;
            if (i_in_valid && !i_flush) begin
               wr_en = 1'b1;
               if (x_cnt_q == X_LAST) begin
                  x_cnt_d = '0;
                  state_d = ST_DRAIN;
               end else begin
                  x_cnt_d = x_cnt_q + XC_W'(1);
               end
            end
         end
         ST_DRAIN: begin
            o_out_valid = 1'b1;
            o_out_data  = buf_q[y_cnt_q];
            o_out_idx   = y_cnt_q;
            o_out_last  = (y_cnt_q == Y_LAST);
            if (i_out_ready && !i_flush) begin
               if (y_cnt_q == Y_LAST) begin
                  y_cnt_d = '0;
                  state_d = ST_FILL;
               end else begin
                  y_cnt_d = y_cnt_q + YC_W'(1);
               end
            end
         end
      endcase

      // Flush aborts the block but leaves stale buffer contents in place.
      if (i_flush) begin
         state_d = ST_FILL;
         x_cnt_d = '0;
         y_cnt_d = '0;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_FILL;
         x_cnt_q <= '0;
         y_cnt_q <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         x_cnt_q <= x_cnt_d;
         y_cnt_q <= y_cnt_d;
         if (wr_en) begin
            for (int y = 0; y < Y_WIDTH; y++) begin
               buf_q[y][x_cnt_q] <= i_in_data[y];
            end
         end
      end
   end

endmodule

// File: tb/tb_tt_reshape_stream.sv
// tb/tb_tt_reshape_stream.sv - scoreboard bench for tt_reshape_stream at 32/4, 4/2 and 1/1
`timescale 1ns/1ps
module tb_tt_reshape_stream;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 32x4 instance: random regression
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_flush;
   logic [3:0]  b_in_data;
   logic [31:0] b_out_data;
   logic [1:0]  b_out_idx;

   // 4x2 instance: directed cases
   logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last, s_flush;
   logic [1:0]  s_in_data;
   logic [3:0]  s_out_data;
   logic [0:0]  s_out_idx;

   // 1x1 instance: degenerate widths
   logic        o_in_valid, o_in_ready, o_out_valid, o_out_ready, o_out_last, o_flush;
   logic [0:0]  o_in_data;
   logic [0:0]  o_out_data;
   logic [0:0]  o_out_idx;

   tt_reshape_stream #(.X_WIDTH(32), .Y_WIDTH(4)) u_big (
      .i_clk(clk), .i_reset(rst), .i_in_valid(b_in_valid), .o_in_ready(b_in_ready),
      .i_in_data(b_in_data), .o_out_valid(b_out_valid), .i_out_ready(b_out_ready),
      .o_out_data(b_out_data), .o_out_idx(b_out_idx), .o_out_last(b_out_last), .i_flush(b_flush)
   );

   tt_reshape_stream #(.X_WIDTH(4), .Y_WIDTH(2)) u_small (
      .i_clk(clk), .i_reset(rst), .i_in_valid(s_in_valid), .o_in_ready(s_in_ready),
      .i_in_data(s_in_data), .o_out_valid(s_out_valid), .i_out_ready(s_out_ready),
      .o_out_data(s_out_data), .o_out_idx(s_out_idx), .o_out_last(s_out_last), .i_flush(s_flush)
   );

   tt_reshape_stream #(.X_WIDTH(1), .Y_WIDTH(1)) u_one (
      .i_clk(clk), .i_reset(rst), .i_in_valid(o_in_valid), .o_in_ready(o_in_ready),
      .i_in_data(o_in_data), .o_out_valid(o_out_valid), .i_out_ready(o_out_ready),
      .o_out_data(o_out_data), .o_out_idx(o_out_idx), .o_out_last(o_out_last), .i_flush(o_flush)
   );

   // Reference model state: accepted beats of the block in progress, expected {last, idx, row}.
   logic [3:0]  b_beats[$];
   logic [1:0]  s_beats[$];
   logic [34:0] bq[$];
   logic [5:0]  sq[$];
   logic        b_rand_on;
   logic        s_expect_ready;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s: condition not reached", name);
   endtask

   // Row y of the transposed block holds bit y of every accepted column, column x at bit x.
   task automatic b_model_push(input logic [3:0] d);
      logic [31:0] row;
      b_beats.push_back(d);
      if (b_beats.size() == 32) begin
         for (int y = 0; y < 4; y++) begin
            row = '0;
            for (int x = 0; x < 32; x++) row[x] = b_beats[x][y];
            bq.push_back({(y == 3), 2'(y), row});
         end
         b_beats.delete();
      end
   endtask

   task automatic s_model_push(input logic [1:0] d);
      logic [3:0] row;
      s_beats.push_back(d);
      if (s_beats.size() == 4) begin
         for (int y = 0; y < 2; y++) begin
            row = '0;
            for (int x = 0; x < 4; x++) row[x] = s_beats[x][y];
            sq.push_back({(y == 1), 1'(y), row});
         end
         s_beats.delete();
      end
   endtask

   task automatic s_send(input logic [1:0] d);
      int   n;
      logic acc;
      n = 0;
      acc = 1'b0;
      s_in_valid = 1'b1;
      s_in_data  = d;
      while (!acc && n < 200) begin
         @(negedge clk);
         if (s_in_ready) acc = 1'b1;
         else n++;
      end
      if (acc) begin
         @(posedge clk); #1;
         s_model_push(d);
      end else begin
         fail_now("small_in_accept_timeout");
      end
      s_in_valid = 1'b0;
   endtask

   task automatic b_send(input logic [3:0] d);
      int   n;
      logic acc;
      n = 0;
      acc = 1'b0;
      b_in_valid = 1'b1;
      b_in_data  = d;
      while (!acc && n < 500) begin
         @(negedge clk);
         if (b_in_ready) acc = 1'b1;
         else n++;
      end
      if (acc) begin
         @(posedge clk); #1;
         b_model_push(d);
      end else begin
         fail_now("big_in_accept_timeout");
      end
      b_in_valid = 1'b0;
   endtask

   task automatic s_wait_idle(input string name);
      int n;
      n = 0;
      while (!(sq.size() == 0 && s_in_ready && !s_out_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) fail_now(name);
      @(posedge clk); #1;
   endtask

   task automatic s_flush_pulse();
      s_flush = 1'b1;
      s_beats.delete();
      sq.delete();
      @(posedge clk); #1;
      s_flush = 1'b0;
   endtask

   // Monitors: pop and compare on every output handshake that is not pre-empted by flush.
   always @(negedge clk) begin
      if (!rst && b_out_valid && b_out_ready && !b_flush) begin
         if (bq.size() == 0) fail_now("big_unexpected_row");
         else chk("big_row", 64'({b_out_last, b_out_idx, b_out_data}), 64'(bq.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (s_expect_ready) begin
         chk("small_in_ready_after_last", 64'(s_in_ready), 64'd1);
         s_expect_ready = 1'b0;
      end
      if (!rst && s_out_valid && s_out_ready && !s_flush) begin
         if (sq.size() == 0) begin
            fail_now("small_unexpected_row");
         end else begin
            chk("small_row", 64'({s_out_last, s_out_idx, s_out_data}), 64'(sq.pop_front()));
            if (s_out_last) s_expect_ready = 1'b1;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (b_rand_on) b_out_ready = ($urandom_range(0, 3) != 0);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0; failures = 0;
      b_rand_on = 1'b0; s_expect_ready = 1'b0;
      b_in_valid = 0; b_in_data = '0; b_out_ready = 0; b_flush = 0;
      s_in_valid = 0; s_in_data = '0; s_out_ready = 0; s_flush = 0;
      o_in_valid = 0; o_in_data = '0; o_out_ready = 0; o_flush = 0;
      rst = 1'b1;
      #12 rst = 1'b0;
      @(negedge clk);

      chk("rst_small_in_ready", 64'(s_in_ready), 64'd1);
      chk("rst_small_out_valid", 64'(s_out_valid), 64'd0);
      chk("rst_small_outs", 64'({s_out_last, s_out_idx, s_out_data}), 64'd0);
      chk("rst_big_ready_valid", 64'({b_in_ready, b_out_valid}), 64'b10);
      chk("rst_big_outs", 64'({b_out_last, b_out_idx, b_out_data}), 64'd0);
      chk("rst_one_ready_valid", 64'({o_in_ready, o_out_valid}), 64'b10);

      // Basic transpose with the consumer always ready
      @(posedge clk); #1;
      s_out_ready = 1'b1;
      s_send(2'b01); s_send(2'b10); s_send(2'b11); s_send(2'b00);
      @(negedge clk);
      chk("basic_latency_valid", 64'(s_out_valid), 64'd1);
      chk("basic_first_row", 64'({s_out_idx, s_out_data}), 64'({1'b0, 4'b0101}));
      s_wait_idle("basic_drain_timeout");

      // Backpressure: five stalled cycles must hold row 0
      s_out_ready = 1'b0;
      s_send(2'b01); s_send(2'b10); s_send(2'b11); s_send(2'b00);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_data", 64'(s_out_data), 64'h5);
         chk("stall_idx_ready_valid", 64'({s_out_idx, s_in_ready, s_out_valid}), 64'b001);
      end
      @(posedge clk); #1;
      s_out_ready = 1'b1;
      s_wait_idle("stall_drain_timeout");

      // Input bubbles: valid alternates with idle cycles
      s_send(2'b01); @(posedge clk); #1;
      s_send(2'b10); @(posedge clk); #1;
      s_send(2'b11); @(posedge clk); #1;
      s_send(2'b00);
      s_wait_idle("bubble_drain_timeout");

      // Flush in FILL after two beats, then a fresh all-ones block
      s_send(2'b01); s_send(2'b10);
      s_flush_pulse();
      s_send(2'b11); s_send(2'b11); s_send(2'b11); s_send(2'b11);
      s_wait_idle("flush_fill_drain_timeout");

      // Flush in DRAIN after row 0, asserted together with ready to exercise priority
      s_out_ready = 1'b0;
      s_send(2'b01); s_send(2'b10); s_send(2'b11); s_send(2'b00);
      s_out_ready = 1'b1;
      @(posedge clk); #1;
      s_flush_pulse();
      @(negedge clk);
      chk("flush_drain_valid", 64'(s_out_valid), 64'd0);
      chk("flush_drain_in_ready", 64'(s_in_ready), 64'd1);
      @(negedge clk);
      chk("flush_drain_no_row1", 64'(s_out_valid), 64'd0);
      @(posedge clk); #1;
      s_send(2'b10); s_send(2'b01); s_send(2'b00); s_send(2'b11);
      s_wait_idle("post_flush_drain_timeout");

      // Asynchronous reset mid-DRAIN, off the clock edge
      s_out_ready = 1'b0;
      s_send(2'b11); s_send(2'b01); s_send(2'b10); s_send(2'b11);
      @(negedge clk);
      chk("pre_reset_valid", 64'(s_out_valid), 64'd1);
      #2 rst = 1'b1;
      sq.delete();
      s_beats.delete();
      #1;
      chk("async_rst_ready_valid", 64'({s_in_ready, s_out_valid}), 64'b10);
      chk("async_rst_outs", 64'({s_out_last, s_out_idx, s_out_data}), 64'd0);
      @(posedge clk); #3 rst = 1'b0;
      @(posedge clk); #1;
      s_out_ready = 1'b1;
      s_send(2'b01); s_send(2'b10); s_send(2'b11); s_send(2'b00);
      s_wait_idle("post_reset_drain_timeout");

      // Degenerate 1x1
      o_in_valid = 1'b1; o_in_data = 1'b1;
      @(negedge clk);
      chk("one_in_ready", 64'(o_in_ready), 64'd1);
      @(posedge clk); #1;
      o_in_valid = 1'b0;
      @(negedge clk);
      chk("one_out", 64'({o_out_valid, o_out_last, o_out_idx, o_out_data, o_in_ready}), 64'b11010);
      @(posedge clk); #1;
      o_out_ready = 1'b1;
      @(negedge clk);
      chk("one_out_hold", 64'(o_out_valid), 64'd1);
      @(posedge clk); #1;
      o_out_ready = 1'b0;
      @(negedge clk);
      chk("one_back_to_fill", 64'({o_in_ready, o_out_valid}), 64'b10);

      // Random regression at 32x4 with stalls on both sides
      b_rand_on = 1'b1;
      for (int blk = 0; blk < 6; blk++) begin
         for (int x = 0; x < 32; x++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
               @(posedge clk); #1;
            end
            b_send(4'($urandom));
         end
      end
      begin
         int n;
         n = 0;
         while (bq.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
         end
         if (n >= 3000) fail_now("big_drain_timeout");
      end
      b_rand_on = 1'b0;
      @(posedge clk); #1;
      b_out_ready = 1'b0;
      @(negedge clk);
      chk("big_idle_end", 64'({b_in_ready, b_out_valid}), 64'b10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tt_reshape_stream.md
# tt_reshape_stream

Streaming corner-turn buffer in the VPU datapath. It accepts an X_WIDTH × Y_WIDTH bit matrix one column per beat: each beat is a Y_WIDTH-bit slice for element x. It then emits the matrix one row per beat: each beat is an X_WIDTH-bit word for bit-plane y. This is the time-serialised counterpart of the combinational transpose, for producers and consumers that exchange data one beat at a time over valid/ready interfaces.

## Interface
- X_WIDTH, 32: number of input beats per block; width of each output word; minimum 1.
- Y_WIDTH, 4: width of each input slice; number of output beats per block; minimum 1.
- i_clk  input  1  clock; all state updates on the rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_in_valid  input  1  input beat valid.
- o_in_ready  output  1  block can accept an input beat.
- i_in_data  input  Y_WIDTH  slice for element x = current fill index.
- o_out_valid  output  1  output beat valid.
- i_out_ready  input  1  consumer accepts an output beat.
- o_out_data  output  X_WIDTH  row y of the buffered matrix.
- o_out_idx  output  max(1,$clog2(Y_WIDTH))  row index y of the current output beat.
- o_out_last  output  1  current output beat is row Y_WIDTH-1.
- i_flush  input  1  synchronous abort of the current block.

## Operation
- Storage: buf[Y_WIDTH][X_WIDTH] bits, a fill counter x_cnt of width max(1,$clog2(X_WIDTH)), a drain counter y_cnt of width max(1,$clog2(Y_WIDTH)), and a state register with values FILL and DRAIN.
- FILL:
  - o_in_ready = 1 and o_out_valid = 0.
  - On i_in_valid && o_in_ready: for every y, buf[y][x_cnt] <= i_in_data[y].
  - If x_cnt == X_WIDTH-1, set x_cnt <= 0 and state <= DRAIN; otherwise x_cnt++.
- DRAIN:
  - o_in_ready = 0 and o_out_valid = 1.
  - o_out_data = buf[y_cnt]; o_out_idx = y_cnt; o_out_last = (y_cnt == Y_WIDTH-1).
  - On o_out_valid && i_out_ready: if y_cnt == Y_WIDTH-1, set y_cnt <= 0 and state <= FILL; otherwise y_cnt++.
- When o_out_valid = 0, o_out_data, o_out_idx and o_out_last all drive 0.
- The buffer is never written in DRAIN, so output beats stay stable while stalled. Once asserted, o_out_valid stays high until its handshake or a flush.
- i_flush:
  - Has priority over both handshakes in the same cycle.
  - Next state is FILL with x_cnt = 0 and y_cnt = 0. Buffer contents are left unchanged.
  - The in-flight input beat is dropped and no output beat is consumed.
- Counters never exceed X_WIDTH-1 or Y_WIDTH-1.
- X_WIDTH = 1: every accepted beat moves the block to DRAIN.
- Y_WIDTH = 1: every output handshake returns the block to FILL.

## Timing
- Reset values: state FILL, x_cnt 0, y_cnt 0, buf all 0, o_in_ready 1, o_out_valid 0, o_out_data 0, o_out_idx 0, o_out_last 0.
- o_in_ready, o_out_valid, o_out_data, o_out_idx and o_out_last are decoded combinationally from registered state only; there is no combinational path from any input.
- The last input beat accepted in cycle N gives o_out_valid = 1 with row 0 in cycle N+1.
- The last output handshake in cycle M gives o_in_ready = 1 in cycle M+1.
- Best-case throughput is one block per X_WIDTH + Y_WIDTH cycles. Input and output phases do not overlap.
- Stalls:
  - i_in_valid low in FILL holds x_cnt.
  - i_out_ready low in DRAIN holds y_cnt and all outputs.
- Reset asserted mid-block, in either state, immediately returns all registers to their reset values. The partially filled block is lost.

## Test plan
- Basic transpose, X_WIDTH=4, Y_WIDTH=2:
  - Stimulus: input beats 2'b01, 2'b10, 2'b11, 2'b00 with i_out_ready held 1.
  - Required response: out beat 0 = 4'b0101 (idx 0, last 0), then out beat 1 = 4'b0110 (idx 1, last 1). o_in_ready = 1 the cycle after beat 1.
- Backpressure:
  - Stimulus: same input data, with i_out_ready = 0 for 5 cycles in DRAIN.
  - Required response: o_out_data holds 4'b0101, o_out_idx holds 0 and o_in_ready holds 0 throughout the stall. The sequence completes normally once i_out_ready rises.
- Input bubbles:
  - Stimulus: i_in_valid toggled 1,0,1,0,… across the four input beats.
  - Required response: x_cnt advances only on handshakes; outputs are identical to the basic transpose case.
- Flush:
  - Stimulus (a): i_flush in FILL after 2 beats, then a new full block 2'b11, 2'b11, 2'b11, 2'b11.
    Required response: outputs 4'b1111, 4'b1111.
  - Stimulus (b): i_flush in DRAIN after row 0 has been consumed.
    Required response: o_out_valid = 0 the next cycle; o_in_ready = 1; no row 1 beat is emitted.
- Async reset:
  - Stimulus: i_reset asserted mid-DRAIN, off the clock edge.
  - Required response: o_out_valid = 0 and o_in_ready = 1 without waiting for a clock edge; all outputs at their reset values.
- Degenerate widths and random regression:
  - Stimulus: X_WIDTH=1, Y_WIDTH=1; input 1'b1.
    Required response: one output 1'b1 with last = 1, returning to FILL after its handshake.
  - Stimulus: random blocks at the default 32/4 widths with random stalls on both sides.
    Required response: every output row y equals {in_beat[X_WIDTH-1][y], …, in_beat[0][y]}.
